// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32I pipeline.
// Drives enable/flush of the IF/ID, ID/EX, EX/MEM and MEM/WB stage registers and the PC enable.
// It resolves three kinds of event:
//   - data-memory waits
//   - EX-stage redirects
//   - load-use hazards
// Priority is in that order: a memory wait beats a redirect, which beats a load-use hazard.
// Saturating perf counters track stalled cycles and accepted redirects.
// Stage control outputs are combinational from state and inputs.
// State, counters and the sticky timeout flag are registered.
module pipe_hazard_ctrl #(
  parameter int REDIRECT_BUBBLES = 1,
  parameter int MEM_TIMEOUT      = 255,
  parameter int CNT_W            = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_load,
  input  logic             ex_redirect,
  input  logic             mem_req,
  input  logic             mem_done,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_flush,
  output logic             exmem_en,
  output logic             exmem_flush,
  output logic             memwb_en,
  output logic             memwb_flush,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [1:0]       state
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam int BUB_W  = 3;

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_MEM_WAIT = 2'd1;
  localparam logic [1:0] ST_REDIRECT = 2'd2;

  logic [BUB_W-1:0]  bub_cnt, bub_nx;
  logic [WAIT_W-1:0] wait_cnt, wait_nx;
  logic [1:0]        state_nx;
  logic              load_use, timeout_hit, mem_stall, redir_take, lu_take;

  // Handshake note: mem_req marks a memory op sitting in MEM.
  // mem_done completes that op in the same cycle; there is no separate ready, and
  // MEM is held frozen until mem_done (or the timeout) arrives.

  // Event decode, in priority order: memory wait, then redirect, then load-use.
  always_comb begin
    load_use    = ex_load && (ex_rd != 5'd0) &&
                  ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));
    timeout_hit = (state == ST_MEM_WAIT) && (wait_cnt >= WAIT_W'(MEM_TIMEOUT));
    mem_stall   = (state == ST_MEM_WAIT) ? (!mem_done && !timeout_hit) : (mem_req && !mem_done);
    redir_take  = ex_redirect && !mem_stall && (state != ST_MEM_WAIT);
    lu_take     = load_use && (state == ST_RUN) && !mem_stall && !ex_redirect;
  end

  // Stage register enables/flushes; reset forces every stage to its NOP value.
  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    ifid_flush  = 1'b0;
    idex_en     = 1'b1;
    idex_flush  = 1'b0;
    exmem_en    = 1'b1;
    exmem_flush = 1'b0;
    memwb_en    = 1'b1;
    memwb_flush = 1'b0;
    if (!rst_n) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_en    = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      memwb_flush = 1'b1;
    end else if (mem_stall) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_flush = 1'b1;
    end else if (redir_take) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
    end else if (state == ST_REDIRECT) begin
      ifid_flush  = 1'b1;
    end else if (lu_take) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_flush  = 1'b1;
    end
  end

  // Next state.
  // The bubble count survives a memory wait, so a redirect can resume afterwards.
  always_comb begin
    state_nx = state;
    bub_nx   = bub_cnt;
    wait_nx  = wait_cnt;
    if (state == ST_MEM_WAIT) begin
      if (mem_stall) begin
        wait_nx = wait_cnt + WAIT_W'(1);
      end else begin
        wait_nx  = '0;
        state_nx = (bub_cnt != '0) ? ST_REDIRECT : ST_RUN;
      end
    end else if (mem_stall) begin
      state_nx = ST_MEM_WAIT;
      wait_nx  = WAIT_W'(1);
    end else if (redir_take) begin
      bub_nx   = BUB_W'(REDIRECT_BUBBLES - 1);
      state_nx = (REDIRECT_BUBBLES > 1) ? ST_REDIRECT : ST_RUN;
    end else if (state == ST_REDIRECT) begin
      bub_nx   = bub_cnt - BUB_W'(1);
      state_nx = (bub_cnt <= BUB_W'(1)) ? ST_RUN : ST_REDIRECT;
    end else begin
      state_nx = ST_RUN;
    end
  end

  // Registered state, sticky timeout flag and saturating perf counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_RUN;
      bub_cnt     <= '0;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
      stall_cnt   <= '0;
      flush_cnt   <= '0;
    end else begin
      state    <= state_nx;
      bub_cnt  <= bub_nx;
      wait_cnt <= wait_nx;
      if (timeout_hit && !mem_done) mem_timeout <= 1'b1;
      if (!pc_en && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (redir_take && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (REDIRECT_BUBBLES=3, MEM_TIMEOUT=8, CNT_W=4).
// Each step drives one cycle of stimulus and pushes the expected item to exp_q.
// The expected item holds stage controls, state, timeout and counters.
// A negedge sampler pops one item per cycle and compares it against the DUT.
module tb_pipe_hazard_ctrl;

  localparam int CNT_W = 4;
  localparam int W     = 20;

  // Expected control words, bit order:
  // pc, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush, memwb_en, memwb_flush
  localparam logic [8:0] C_RST = 9'b001010101;
  localparam logic [8:0] C_NRM = 9'b110101010;
  localparam logic [8:0] C_LU  = 9'b000111010;
  localparam logic [8:0] C_RD  = 9'b111111010;
  localparam logic [8:0] C_BUB = 9'b111101010;
  localparam logic [8:0] C_MST = 9'b000000011;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic id_use_rs1 = 1'b0, id_use_rs2 = 1'b0, ex_load = 1'b0;
  logic ex_redirect = 1'b0, mem_req = 1'b0, mem_done = 1'b0;
  logic pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
  logic exmem_en, exmem_flush, memwb_en, memwb_flush, mem_timeout;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic [1:0] state;

  logic [W-1:0] exp_q[$];
  logic [CNT_W-1:0] exp_stall = '0, exp_flush = '0;
  int n_chk = 0;
  int n_pass = 0;

  pipe_hazard_ctrl #(.REDIRECT_BUBBLES(3), .MEM_TIMEOUT(8), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_load(ex_load), .ex_redirect(ex_redirect),
    .mem_req(mem_req), .mem_done(mem_done),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
    .idex_en(idex_en), .idex_flush(idex_flush),
    .exmem_en(exmem_en), .exmem_flush(exmem_flush),
    .memwb_en(memwb_en), .memwb_flush(memwb_flush),
    .mem_timeout(mem_timeout), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .state(state)
  );

  // Clock.
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // Driver for one cycle.
  // The lu code selects the ID/EX operand pattern:
  //   0 idle
  //   1 rs1 hazard
  //   2 rd=x0
  //   3 rs2 hazard
  //   4 rs1 match with use off
  task automatic step(input logic r, input int lu, input logic rd, input logic mq, input logic md,
                      input logic [8:0] ctl, input logic [1:0] st, input logic to);
    @(posedge clk);
    #1;
    rst_n = r;
    ex_redirect = rd;
    mem_req = mq;
    mem_done = md;
    ex_load = (lu != 0);
    case (lu)
      1: begin ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1; id_rs2 = 5'($urandom_range(10, 31)); id_use_rs2 = 1; end
      2: begin ex_rd = 0; id_rs1 = 0; id_use_rs1 = 1; id_rs2 = 0; id_use_rs2 = 1; end
      3: begin ex_rd = 9; id_rs1 = 3; id_use_rs1 = 1; id_rs2 = 9; id_use_rs2 = 1; end
      4: begin ex_rd = 5; id_rs1 = 5; id_use_rs1 = 0; id_rs2 = 6; id_use_rs2 = 1; end
      default: begin
        ex_rd = 5'($urandom_range(0, 31)); id_rs1 = 5'($urandom_range(0, 31));
        id_rs2 = 5'($urandom_range(0, 31)); id_use_rs1 = 1; id_use_rs2 = 1;
      end
    endcase
    exp_q.push_back({ctl, st, to, exp_stall, exp_flush});
    if (!r) begin
      exp_stall = '0;
      exp_flush = '0;
    end else begin
      if (!ctl[8] && (exp_stall != '1)) exp_stall = exp_stall + 1'b1;
      if (ctl[8] && ctl[4] && (exp_flush != '1)) exp_flush = exp_flush + 1'b1;
    end
  endtask

  // Scoreboard: one expected item per cycle, compared away from the clock edge.
  always @(negedge clk) begin
    logic [W-1:0] it;
    if (exp_q.size() > 0) begin
      it = exp_q.pop_front();
      check("ctl", {23'b0, pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
                    exmem_en, exmem_flush, memwb_en, memwb_flush}, {23'b0, it[19:11]});
      check("state", {30'b0, state}, {30'b0, it[10:9]});
      check("mem_timeout", {31'b0, mem_timeout}, {31'b0, it[8]});
      check("stall_cnt", {28'b0, stall_cnt}, {28'b0, it[7:4]});
      check("flush_cnt", {28'b0, flush_cnt}, {28'b0, it[3:0]});
    end
  end

  initial begin
    // Reset for two cycles, then release.
    step(0, 0, 0, 0, 0, C_RST, 0, 0);
    step(0, 0, 0, 0, 0, C_RST, 0, 0);
    step(1, 0, 0, 0, 0, C_NRM, 0, 0);
    // Load-use hazard patterns.
    step(1, 1, 0, 0, 0, C_LU,  0, 0);
    step(1, 0, 0, 0, 0, C_NRM, 0, 0);
    step(1, 2, 0, 0, 0, C_NRM, 0, 0);
    step(1, 3, 0, 0, 0, C_LU,  0, 0);
    step(1, 4, 0, 0, 0, C_NRM, 0, 0);
    // Redirect with 3 bubbles; load-use during the bubbles is ignored.
    step(1, 1, 1, 0, 0, C_RD,  0, 0);
    step(1, 1, 0, 0, 0, C_BUB, 2, 0);
    step(1, 1, 0, 0, 0, C_BUB, 2, 0);
    step(1, 1, 0, 0, 0, C_LU,  0, 0);
    step(1, 0, 0, 0, 0, C_NRM, 0, 0);
    // A redirect that arrives during the bubbles restarts the bubble count.
    step(1, 0, 1, 0, 0, C_RD,  0, 0);
    step(1, 0, 0, 0, 0, C_BUB, 2, 0);
    step(1, 0, 1, 0, 0, C_RD,  2, 0);
    step(1, 0, 0, 0, 0, C_BUB, 2, 0);
    step(1, 0, 0, 0, 0, C_BUB, 2, 0);
    step(1, 0, 0, 0, 0, C_NRM, 0, 0);
    // Memory wait: 4 stalled cycles, then mem_done releases.
    step(1, 0, 0, 1, 0, C_MST, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 1, 0, C_MST, 1, 0);
    step(1, 0, 0, 1, 1, C_NRM, 1, 0);
    step(1, 0, 0, 1, 1, C_NRM, 0, 0);
    // Memory wait beats a simultaneous redirect and load-use.
    step(1, 1, 1, 1, 0, C_MST, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 1, 1, 1, 0, C_MST, 1, 0);
    step(1, 1, 1, 1, 1, C_NRM, 1, 0);
    step(1, 0, 0, 0, 0, C_NRM, 0, 0);
    // A memory wait inside the redirect bubbles resumes the remaining bubbles.
    step(1, 0, 1, 0, 0, C_RD,  0, 0);
    step(1, 0, 0, 1, 0, C_MST, 2, 0);
    step(1, 0, 0, 1, 0, C_MST, 1, 0);
    step(1, 0, 0, 1, 1, C_NRM, 1, 0);
    step(1, 0, 0, 0, 0, C_BUB, 2, 0);
    step(1, 0, 0, 0, 0, C_BUB, 2, 0);
    step(1, 0, 0, 0, 0, C_NRM, 0, 0);
    // Timeout: mem_done never comes; release after 8 stalled cycles.
    // mem_timeout is sticky, and stall_cnt saturates during this sequence.
    step(1, 0, 0, 1, 0, C_MST, 0, 0);
    for (int i = 0; i < 7; i++) step(1, 0, 0, 1, 0, C_MST, 1, 0);
    step(1, 0, 0, 0, 0, C_NRM, 1, 0);
    step(1, 0, 0, 0, 0, C_NRM, 0, 1);
    step(1, 0, 0, 0, 0, C_NRM, 0, 1);
    // Reset in the second MEM_WAIT cycle aborts the wait and clears everything.
    step(1, 0, 0, 1, 0, C_MST, 0, 1);
    step(1, 0, 0, 1, 0, C_MST, 1, 1);
    step(0, 0, 0, 1, 0, C_RST, 1, 1);
    step(1, 0, 0, 0, 0, C_NRM, 0, 0);
    step(1, 1, 0, 0, 0, C_LU,  0, 0);
    step(1, 0, 0, 0, 0, C_NRM, 0, 0);
    @(negedge clk);
    #1;
    check("drain", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
